// File: rtl/module_bcd_entry_reg.sv
// Keypad digit-entry register: accumulates BCD digits calculator style, supports
// backspace/clear, and commits the entered number through a valid/ready handshake.
module module_bcd_entry_reg #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic [4*DIGITS-1:0]   bcd_work,
    output logic [CNT_W-1:0]      work_count,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned W = 4 * DIGITS;

    localparam logic [3:0] KeyMaxDigit = 4'h9;
    localparam logic [3:0] KeyBksp     = 4'hA;
    localparam logic [3:0] KeyClear    = 4'hB;
    localparam logic [3:0] KeyEnter    = 4'hC;

    localparam logic [CNT_W-1:0] CntFull = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic [0:0] {StEntry, StHold} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     work_q, work_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [W-1:0]     out_q, out_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEntry;
            work_q  <= '0;
            wcnt_q  <= '0;
            out_q   <= '0;
            ocnt_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            wcnt_q  <= wcnt_d;
            out_q   <= out_d;
            ocnt_q  <= ocnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        wcnt_d  = wcnt_q;
        out_d   = out_q;
        ocnt_d  = ocnt_q;
        valid_d = valid_q;
        err_d   = 1'b0;

        case (state_q)
            StEntry: begin
                if (key_valid) begin
                    if (key_code <= KeyMaxDigit) begin
                        if (wcnt_q < CntFull) begin
                            work_d = {work_q[W-5:0], key_code};
                            wcnt_d = wcnt_q + CntOne;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (key_code)
                            KeyBksp: begin
                                if (wcnt_q != '0) begin
                                    work_d = {4'h0, work_q[W-1:4]};
                                    wcnt_d = wcnt_q - CntOne;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            KeyClear: begin
                                work_d = '0;
                                wcnt_d = '0;
                            end
                            KeyEnter: begin
                                // Enter on an empty entry is silently dropped.
                                if (wcnt_q != '0) begin
                                    out_d   = work_q;
                                    ocnt_d  = wcnt_q;
                                    valid_d = 1'b1;
                                    work_d  = '0;
                                    wcnt_d  = '0;
                                    state_d = StHold;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StHold: begin
                // Keys are ignored here, including one coincident with out_ready.
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StEntry;
                end
            end
            default: state_d = StEntry;
        endcase
    end

    assign bcd_work   = work_q;
    assign work_count = wcnt_q;
    assign bcd_out    = out_q;
    assign out_count  = ocnt_q;
    assign out_valid  = valid_q;
    assign busy       = (state_q == StHold);
    assign err        = err_q;

endmodule

// File: doc/module_bcd_entry_reg.md
Name: module_bcd_entry_reg

Overview:
- Parametrised keypad digit-entry register: accumulates up to DIGITS BCD digits, calculator style, with the newest digit entering the least-significant position.
- Supports backspace and clear. Commits the entered number to a held output word through a valid/ready handshake.
- Sits between the keypad decoder/debouncer and the arithmetic/display consumers, generalising the fixed two-digit units/tens capture.

Parameters:
- DIGITS, 4, number of BCD digits held (≥2).
- CNT_W, $clog2(DIGITS+1), width of digit-count outputs (derived; not to be overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- key_valid  in  1  one-cycle strobe: key_code is valid this cycle
- key_code  in  4  0x0–0x9 digit; 0xA backspace; 0xB clear; 0xC enter; 0xD–0xF ignored
- bcd_work  out  4*DIGITS  live entry value, digit 0 = bits [3:0]
- work_count  out  CNT_W  digits currently entered (0..DIGITS)
- bcd_out  out  4*DIGITS  committed value, stable while out_valid=1
- out_count  out  CNT_W  digit count of committed value
- out_valid  out  1  committed value available
- out_ready  in  1  consumer accepts bcd_out
- busy  out  1  high in HOLD state; keys ignored
- err  out  1  one-cycle pulse on rejected key (overflow or empty backspace)

Behaviour:
- Reset: rst=1 at a clock edge forces state ENTRY and sets bcd_work, work_count, bcd_out, out_count, out_valid, busy and err to 0. Reset has priority over every other input. Reset during HOLD drops out_valid on the next cycle with no handshake.
- State ENTRY (busy=0). On key_valid=1:
  - Digit, work_count<DIGITS: bcd_work <= {bcd_work[4*DIGITS-5:0], key_code}; work_count+1.
  - Digit, work_count==DIGITS: digit dropped, bcd_work unchanged, err=1 for one cycle.
  - Backspace, work_count>0: bcd_work <= {4'h0, bcd_work[4*DIGITS-1:4]}; work_count−1.
  - Backspace, work_count==0: no change, err=1.
  - Clear: bcd_work<=0, work_count<=0 (no err, even when already empty).
  - Enter, work_count>0: bcd_out<=bcd_work, out_count<=work_count, out_valid<=1, bcd_work<=0, work_count<=0, go to HOLD.
  - Enter, work_count==0: ignored, no err.
  - Codes 0xD–0xF: ignored, no err.
- State HOLD (busy=1):
  - Every key_valid is ignored with no err and no state change.
  - out_valid=1, and bcd_out/out_count are held constant.
  - When out_ready=1: out_valid<=0 and go to ENTRY on the next edge. bcd_out keeps its last value after the handshake.
  - A key arriving in the same cycle as the accepting out_ready is ignored, because busy is still 1 that cycle.
- out_ready is don't-care in ENTRY.
- Latency: all outputs update one cycle after the key edge (registered). One key is processed per cycle; back-to-back strobes are legal.
- err is registered and high for exactly one cycle per rejected key.
- Digit validity: values >9 never enter bcd_work.

Test Plan:
- DIGITS=4 reset: rst=1 for 2 cycles -> all outputs 0, busy=0. Then keys 1,2,3 -> bcd_work=0x0123, work_count=3, each update one cycle after its strobe.
- Overflow: keys 9,8,7,6,5 -> after the 4th key bcd_work=0x9876, count=4; 5th key -> err pulse of one cycle, bcd_work still 0x9876.
- Edit: keys 4,5,backspace,7 -> 0x0047, count=2. Clear -> 0x0000, count 0. Backspace on empty -> err=1, count 0.
- Commit handshake: keys 3,1, enter with out_ready=0 for 5 cycles -> bcd_out=0x0031, out_count=2, out_valid=1, busy=1, bcd_work=0. Key 9 during HOLD ignored. out_ready=1 -> out_valid=0 and busy=0 next cycle; key 9 then gives bcd_work=0x0009.
- Enter on empty entry -> no out_valid, no err, state stays ENTRY.
- Reset mid-HOLD: commit 0x0012, assert rst while out_valid=1 -> next cycle out_valid=0, bcd_out=0, busy=0. Also run DIGITS=2: keys 5,6,7 -> 0x56 and err.
